wash_cycle_ctrl: RTL and testbench

//  Main washing-machine sequencer; drives the cycle timer's control inputs.

---
 rtl/wash_cycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl -- washing-machine cycle sequencer.
//
// Walks IDLE -> FILL -> WASH -> RINSE -> SPIN -> IDLE. When double wash is
// selected, RINSE loops back to WASH exactly once before SPIN. Every timed
// state is left when the external timer reports finish while no pause is
// requested. A watchdog forces a sticky FAULT if a timed state is occupied
// for WDOG_MAX unpaused cycles without a finish.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   coin_in         start request (level), honoured only in IDLE
//   double_wash     double-wash select, latched with coin_in
//   clk_freq_sel    timer clock-rate code, latched with coin_in
//   pause_req       lid-open / pause request (level)
//   timer_finish    timer expired (level or pulse)
//   state_time      one-cycle timer reload pulse on entry to each timed state
//   double_time     timer doubles duration (high during WASH when double)
//   timer_pause     registered pause_req while in a timed state
//   clk_freq        latched clk_freq_sel
//   wash_done       one-cycle pulse when SPIN completes
//   fault           sticky watchdog error
//   state           IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 FAULT=7
module wash_cycle_ctrl #(
  parameter int unsigned          WDOG_W   = 32,
  parameter logic [WDOG_W-1:0]    WDOG_MAX = WDOG_W'(1000000)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic [1:0] clk_freq_sel,
  input  logic       pause_req,
  input  logic       timer_finish,
  output logic       state_time,
  output logic       double_time,
  output logic       timer_pause,
  output logic [1:0] clk_freq,
  output logic       wash_done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    FAULT = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic              dbl_q, dbl_d;
  logic              second_q, second_d;
  logic [1:0]        freq_q, freq_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              state_time_q, state_time_d;
  logic              double_time_q, double_time_d;
  logic              timer_pause_q, timer_pause_d;
  logic              wash_done_q, wash_done_d;
  logic              fault_q, fault_d;

  logic              timed_q;
  logic              timed_d;
  logic              advance;
  logic [WDOG_W-1:0] wdog_inc;

  assign timed_q  = state_q inside {FILL, WASH, RINSE, SPIN};
  assign timed_d  = state_d inside {FILL, WASH, RINSE, SPIN};
  // Pause has priority over finish.
  assign advance  = timed_q && timer_finish && !pause_req;
  assign wdog_inc = wdog_q + WDOG_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dbl_q         <= 1'b0;
      second_q      <= 1'b0;
      freq_q        <= '0;
      wdog_q        <= '0;
      state_time_q  <= 1'b0;
      double_time_q <= 1'b0;
      timer_pause_q <= 1'b0;
      wash_done_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dbl_q         <= dbl_d;
      second_q      <= second_d;
      freq_q        <= freq_d;
      wdog_q        <= wdog_d;
      state_time_q  <= state_time_d;
      double_time_q <= double_time_d;
      timer_pause_q <= timer_pause_d;
      wash_done_q   <= wash_done_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state logic, including option latching and the watchdog.
  always_comb begin
    state_d  = state_q;
    dbl_d    = dbl_q;
    second_d = second_q;
    freq_d   = freq_q;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE: begin
        if (coin_in) begin
          state_d = FILL;
          dbl_d   = double_wash;
          freq_d  = clk_freq_sel;
          wdog_d  = '0;
        end
      end
      FILL, WASH, RINSE, SPIN: begin
        if (advance) begin
          wdog_d = '0;
          case (state_q)
            FILL:  state_d = WASH;
            WASH:  state_d = RINSE;
            RINSE: begin
              if (dbl_q && !second_q) begin
                state_d  = WASH;
                second_d = 1'b1;
              end else begin
                state_d = SPIN;
              end
            end
            default: begin
              state_d  = IDLE;
              second_d = 1'b0;
            end
          endcase
        end else if (!pause_req) begin
          // The cycle that would make the count reach WDOG_MAX trips the fault.
          if (wdog_inc == WDOG_MAX) begin
            state_d = FAULT;
          end else begin
            wdog_d = wdog_inc;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the upcoming state so they line up
  // with the state they describe.
  always_comb begin
    state_time_d  = timed_d && (state_d != state_q);
    double_time_d = (state_d == WASH) && dbl_d;
    timer_pause_d = pause_req && timed_d;
    wash_done_d   = (state_q == SPIN) && advance;
    fault_d       = fault_q || (state_d == FAULT);
  end

  assign state_time  = state_time_q;
  assign double_time = double_time_q;
  assign timer_pause = timer_pause_q;
  assign clk_freq    = freq_q;
  assign wash_done   = wash_done_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
module tb_wash_cycle_ctrl;

  localparam int WD = 50;

  logic       clk;
  logic       rst_n;
  logic       coin_in;
  logic       double_wash;
  logic [1:0] clk_freq_sel;
  logic       pause_req;
  logic       timer_finish;
  logic       state_time;
  logic       double_time;
  logic       timer_pause;
  logic [1:0] clk_freq;
  logic       wash_done;
  logic       fault;
  logic [2:0] state;

  wash_cycle_ctrl #(.WDOG_W(32), .WDOG_MAX(32'd50)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_in      (coin_in),
    .double_wash  (double_wash),
    .clk_freq_sel (clk_freq_sel),
    .pause_req    (pause_req),
    .timer_finish (timer_finish),
    .state_time   (state_time),
    .double_time  (double_time),
    .timer_pause  (timer_pause),
    .clk_freq     (clk_freq),
    .wash_done    (wash_done),
    .fault        (fault),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the whole program is laid out as a list of stages at
  // coin time, and a position walks along it.
  int   m_plan[$];
  int   m_pos, m_cnt;
  bit   m_idle, m_fault, m_dbl;
  logic [1:0] m_freq;
  int   e_state;
  bit   e_st, e_dt, e_tp, e_done;

  function automatic void model_reset();
    m_plan.delete();
    m_pos = 0; m_cnt = 0; m_idle = 1; m_fault = 0; m_dbl = 0; m_freq = 2'd0;
    e_state = 0; e_st = 0; e_dt = 0; e_tp = 0; e_done = 0;
  endfunction

  function automatic void model_step(bit ci, bit dw, logic [1:0] fs, bit pr, bit tf);
    e_st = 0; e_done = 0;
    if (m_fault) begin
    end else if (m_idle) begin
      if (ci) begin
        m_plan.delete();
        m_plan.push_back(1); m_plan.push_back(2); m_plan.push_back(3);
        if (dw) begin m_plan.push_back(2); m_plan.push_back(3); end
        m_plan.push_back(4);
        m_pos = 0; m_cnt = 0; m_idle = 0; m_dbl = dw; m_freq = fs; e_st = 1;
      end
    end else if (!pr) begin
      if (tf) begin
        m_pos++; m_cnt = 0;
        if (m_pos == m_plan.size()) begin m_idle = 1; e_done = 1; end
        else e_st = 1;
      end else begin
        m_cnt++;
        if (m_cnt >= WD) m_fault = 1;
      end
    end
    e_state = m_fault ? 7 : (m_idle ? 0 : m_plan[m_pos]);
    e_tp    = pr && !m_fault && !m_idle;
    e_dt    = (e_state == 2) && m_dbl;
  endfunction

  // Observation log for the scenario checks.
  logic [31:0] seq_log;
  logic [2:0]  prev_state;
  int st_cnt, done_cnt, dt_cnt, dt_wash_miss;

  task automatic clear_log();
    seq_log = '0; prev_state = state; st_cnt = 0; done_cnt = 0; dt_cnt = 0; dt_wash_miss = 0;
  endtask

  task automatic step(input bit ci, input bit dw, input logic [1:0] fs, input bit pr, input bit tf);
    coin_in = ci; double_wash = dw; clk_freq_sel = fs; pause_req = pr; timer_finish = tf;
    @(posedge clk);
    model_step(ci, dw, fs, pr, tf);
    #1;
    chk("state",       32'(state),       32'(e_state));
    chk("state_time",  32'(state_time),  32'(e_st));
    chk("double_time", 32'(double_time), 32'(e_dt));
    chk("timer_pause", 32'(timer_pause), 32'(e_tp));
    chk("clk_freq",    32'(clk_freq),    32'(m_freq));
    chk("wash_done",   32'(wash_done),   32'(e_done));
    chk("fault",       32'(fault),       32'(m_fault));
    if (state !== prev_state) seq_log = {seq_log[27:0], 1'b0, state};
    prev_state = state;
    st_cnt   += int'(state_time);
    done_cnt += int'(wash_done);
    dt_cnt   += int'(double_time);
    if (state == 3'd2 && !double_time) dt_wash_miss++;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_state"}, 32'(state), 0);
    chk({nm, "_outs"},  32'({state_time, double_time, timer_pause, clk_freq, wash_done, fault}), 0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic apply_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    coin_in = 0; double_wash = 0; clk_freq_sel = 0; pause_req = 0; timer_finish = 0;
    #1;
    model_reset();
    check_zero(nm);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_state = 3'd0;
  endtask

  typedef struct {
    bit ci; bit dw; logic [1:0] fs; bit pr; bit tf;
    logic [2:0] st; bit stt; bit dt; bit tp; bit dn; logic [1:0] fq;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst_n = 1'b0;
    coin_in = 0; double_wash = 0; clk_freq_sel = 0; pause_req = 0; timer_finish = 0;
    model_reset();
    clear_log();

    //          ci dw fs    pr tf  state stt dt tp dn fq
    tbl[0]  = '{0, 0, 2'd0, 0, 0, 3'd0, 0, 0, 0, 0, 2'd0};
    tbl[1]  = '{1, 1, 2'd2, 0, 0, 3'd1, 1, 0, 0, 0, 2'd2};
    tbl[2]  = '{0, 0, 2'd0, 0, 0, 3'd1, 0, 0, 0, 0, 2'd2};
    tbl[3]  = '{0, 0, 2'd0, 0, 1, 3'd2, 1, 1, 0, 0, 2'd2};
    tbl[4]  = '{0, 0, 2'd0, 1, 1, 3'd2, 0, 1, 1, 0, 2'd2};
    tbl[5]  = '{0, 0, 2'd0, 0, 1, 3'd3, 1, 0, 0, 0, 2'd2};
    tbl[6]  = '{0, 0, 2'd0, 0, 1, 3'd2, 1, 1, 0, 0, 2'd2};
    tbl[7]  = '{0, 0, 2'd0, 0, 1, 3'd3, 1, 0, 0, 0, 2'd2};
    tbl[8]  = '{0, 0, 2'd0, 0, 1, 3'd4, 1, 0, 0, 0, 2'd2};
    tbl[9]  = '{1, 0, 2'd1, 0, 0, 3'd4, 0, 0, 0, 0, 2'd2};
    tbl[10] = '{1, 0, 2'd1, 0, 1, 3'd0, 0, 0, 0, 1, 2'd2};
    tbl[11] = '{1, 0, 2'd1, 0, 0, 3'd1, 1, 0, 0, 0, 2'd1};
    tbl[12] = '{0, 0, 2'd0, 0, 1, 3'd2, 1, 0, 0, 0, 2'd1};

    // 1: reset at time zero, then idle without a coin.
    #1;
    check_zero("t1_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 1, 2'd3, 0, 1);
    chk("t1_idle", 32'(state), 0);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ci, tbl[i].dw, tbl[i].fs, tbl[i].pr, tbl[i].tf);
      chk("tbl_state", 32'(state),       32'(tbl[i].st));
      chk("tbl_stt",   32'(state_time),  32'(tbl[i].stt));
      chk("tbl_dt",    32'(double_time), 32'(tbl[i].dt));
      chk("tbl_tp",    32'(timer_pause), 32'(tbl[i].tp));
      chk("tbl_done",  32'(wash_done),   32'(tbl[i].dn));
      chk("tbl_freq",  32'(clk_freq),    32'(tbl[i].fq));
    end

    // 2: single wash, finish pulse every 20 clocks.
    apply_reset("t2_rst");
    clear_log();
    step(1, 0, 2'd1, 0, 0);
    for (int i = 1; i < 200 && done_cnt == 0; i++) step(0, 0, 2'd0, 0, (i % 20) == 19);
    chk("t2_seq",  seq_log, 32'h0001_2340);
    chk("t2_st",   32'(st_cnt), 4);
    chk("t2_done", 32'(done_cnt), 1);
    chk("t2_dt",   32'(dt_cnt), 0);

    // 3: double wash, rate code 2.
    apply_reset("t3_rst");
    clear_log();
    step(1, 1, 2'd2, 0, 0);
    for (int i = 1; i < 400 && done_cnt == 0; i++) step(0, 0, 2'd0, 0, (i % 20) == 19);
    chk("t3_seq",  seq_log, 32'h0123_2340);
    chk("t3_st",   32'(st_cnt), 6);
    chk("t3_done", 32'(done_cnt), 1);
    chk("t3_dtw",  32'(dt_wash_miss), 0);
    chk("t3_dt",   32'(dt_cnt > 0), 1);
    chk("t3_freq", 32'(clk_freq), 32'd2);

    // 4: pause in RINSE with finish held.
    apply_reset("t4_rst");
    step(1, 0, 2'd0, 0, 0);
    step(0, 0, 2'd0, 0, 1);
    step(0, 0, 2'd0, 0, 1);
    chk("t4_rinse", 32'(state), 3);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 2'd0, 1, 1);
      chk("t4_hold", 32'(state), 3);
      chk("t4_tp",   32'(timer_pause), 1);
    end
    step(0, 0, 2'd0, 0, 1);
    chk("t4_spin", 32'(state), 4);
    chk("t4_tp0",  32'(timer_pause), 0);

    // 5: watchdog with no finish after the coin.
    apply_reset("t5_rst");
    step(1, 0, 2'd0, 0, 0);
    for (int i = 1; i < WD; i++) step(0, 0, 2'd0, 0, 0);
    chk("t5_pre",   32'(state), 1);
    chk("t5_pref",  32'(fault), 0);
    step(0, 0, 2'd0, 0, 0);
    chk("t5_fault", 32'({fault, state}), 32'hF);
    for (int i = 0; i < 10; i++) step(1, 1, 2'd3, i[0], 1);
    chk("t5_stuck", 32'({fault, state}), 32'hF);

    // 6: reset while in WASH, then restart.
    apply_reset("t6_pre");
    clear_log();
    step(1, 0, 2'd3, 0, 0);
    step(0, 0, 2'd0, 0, 1);
    step(0, 0, 2'd0, 0, 0);
    chk("t6_wash", 32'(state), 2);
    apply_reset("t6_rst");
    step(0, 0, 2'd0, 0, 0);
    chk("t6_done", 32'(done_cnt + int'(wash_done)), 0);
    step(1, 0, 2'd1, 0, 0);
    chk("t6_fill", 32'({state_time, state}), 32'h9);

    // Randomised traffic against the model; later phases starve the timer.
    apply_reset("rnd_rst");
    for (int i = 0; i < 4000; i++) begin
      int ph;
      ph = i / 1000;
      if ($urandom_range(0, 399) == 0) apply_reset("rnd_rst");
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                $urandom_range(0, 2 + ph * 40) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
